// File: rtl/bram_dac_pkg.sv
// Shared types and constants for the BRAM-to-DAC playback path.
// The BRAM word size and the word/byte address shift are defined here.
package bram_dac_pkg;
  localparam int BYTES_PER_WORD = 64;
  localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam int ADDR_W_DFLT    = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef logic [ADDR_W_DFLT-WORD_SHIFT-1:0] word_idx_t;
endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count. Zero-latency read of the head.
// Pushes into a full FIFO and pops from an empty FIFO are ignored; the caller sizes traffic by credit.
module stream_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bram_dac_streamer.sv
// Loops BRAM words [start,stop) onto AXI-Stream while dac_en is high; first beat RD_LAT+1 cycles after enable.
// Reads are credit-limited so the output FIFO never overflows under tready backpressure; BRAM_DAC_TLAST_EN adds tlast.
module bram_dac_streamer
  import bram_dac_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              dac_en,
  input  logic [31:0]       start_ptr,
  input  logic [31:0]       stop_ptr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_rddata,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
`ifdef BRAM_DAC_TLAST_EN
  output logic              m_axis_tlast,
`endif
  output logic              busy,
  output logic              cfg_err
);
  localparam int WIDX_W = ADDR_W - WORD_SHIFT;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
`ifdef BRAM_DAC_TLAST_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif

  state_t              state_q, state_d;
  logic                dac_en_q;
  logic [WIDX_W-1:0]   start_w_q, start_w_d, stop_w_q, stop_w_d, cur_w_q, cur_w_d;
  logic [WIDX_W-1:0]   start_in, stop_in, cur_inc;
  logic [CNT_W-1:0]    inflight_q, inflight_d, fifo_count;
  logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;
  logic                cfg_err_q, cfg_err_d;
  logic                issue, ret, fifo_empty, fifo_full, pop;
  logic [FIFO_W-1:0]   fifo_din, fifo_dout;
  logic                unused_bits;

  assign start_in    = start_ptr[ADDR_W-1:WORD_SHIFT];
  assign stop_in     = stop_ptr[ADDR_W-1:WORD_SHIFT];
  assign unused_bits = ^{start_ptr[WORD_SHIFT-1:0], stop_ptr[WORD_SHIFT-1:0], fifo_full};
  assign cur_inc     = cur_w_q + WIDX_W'(1);

  // Credit: every issued read already owns a FIFO slot when its data returns.
  assign issue = (state_q == RUN) && dac_en &&
                 ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);
  assign ret        = vld_sr_q[RD_LAT-1];
  assign vld_sr_d   = RD_LAT'({vld_sr_q, issue});
  assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret);

  always_comb begin
    state_d   = state_q;
    start_w_d = start_w_q;
    stop_w_d  = stop_w_q;
    cur_w_d   = cur_w_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      IDLE: begin
        if (dac_en && !dac_en_q) begin
          start_w_d = start_in;
          stop_w_d  = stop_in;
          if (stop_in > start_in) begin
            state_d = RUN;
            cur_w_d = start_in;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!dac_en) state_d = DRAIN;
        else if (issue) cur_w_d = (cur_inc == stop_w_q) ? start_w_q : cur_inc;
      end
      DRAIN: begin
        if (fifo_empty && (inflight_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dac_en_q resets high so a level already present at reset release is not taken as a rise.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      dac_en_q   <= 1'b1;
      start_w_q  <= '0;
      stop_w_q   <= '0;
      cur_w_q    <= '0;
      inflight_q <= '0;
      vld_sr_q   <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dac_en_q   <= dac_en;
      start_w_q  <= start_w_d;
      stop_w_q   <= stop_w_d;
      cur_w_q    <= cur_w_d;
      inflight_q <= inflight_d;
      vld_sr_q   <= vld_sr_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef BRAM_DAC_TLAST_EN
  logic [RD_LAT-1:0] last_sr_q, last_sr_d;
  assign last_sr_d = RD_LAT'({last_sr_q, (cur_inc == stop_w_q)});
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) last_sr_q <= '0;
    else          last_sr_q <= last_sr_d;
  end
  assign fifo_din     = {last_sr_q[RD_LAT-1], bram_rddata};
  assign m_axis_tlast = !fifo_empty && fifo_dout[DATA_W];
`else
  assign fifo_din = bram_rddata;
`endif

  stream_sync_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk    (aclk),
    .rst_n  (aresetn),
    .push_i (ret),
    .din_i  (fifo_din),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .count_o(fifo_count)
  );

  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign bram_en       = issue;
  assign bram_addr     = {cur_w_q, WORD_SHIFT'(0)};
  assign busy          = (state_q != IDLE);
  assign cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_bram_dac_streamer.sv
// Bench for bram_dac_streamer: BRAM model, looping-sequence reference and directed scenarios.
module tb_bram_dac_streamer;
  import bram_dac_pkg::*;

  localparam int DATA_W = 512, ADDR_W = 32, RD_LAT = 2, FIFO_DEPTH = 4, MEM_WORDS = 64;

  logic              aclk = 1'b0;
  logic              aresetn, dac_en, m_axis_tready;
  logic [31:0]       start_ptr, stop_ptr;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en, m_axis_tvalid, busy, cfg_err;
  logic [DATA_W-1:0] bram_rddata, m_axis_tdata;

  always #5 aclk = ~aclk;

  bram_dac_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .dac_en(dac_en),
    .start_ptr(start_ptr), .stop_ptr(stop_ptr),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_rddata(bram_rddata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .cfg_err(cfg_err)
  );

  // BRAM model: data for the address presented in cycle n appears in cycle n+RD_LAT.
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [5:0]        rd_pipe [RD_LAT];
  always @(posedge aclk) begin
    rd_pipe[0] <= bram_addr[11:6];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rddata = mem[rd_pipe[RD_LAT-1]];

  int n_cmp, n_bad;
  int exp_idx, reg_start, reg_stop, beats, outstanding;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: accepted beats must walk start..stop-1 and wrap, data held while stalled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_axis_tvalid, 1'b1);
        chk("hold_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_data", m_axis_tdata, mem[exp_idx]);
        exp_idx = (exp_idx + 1 == reg_stop) ? reg_start : exp_idx + 1;
        beats++;
      end
      outstanding += int'(bram_en) - int'(m_axis_tvalid && m_axis_tready);
      if (bram_en) chk("outstanding_le_depth", outstanding <= FIFO_DEPTH, 1'b1);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_region(input int s, input int e);
    reg_start = s;
    reg_stop  = e;
    exp_idx   = s;
    start_ptr = 32'(s * BYTES_PER_WORD) | 32'($urandom_range(0, 63));
    stop_ptr  = 32'(e * BYTES_PER_WORD) | 32'($urandom_range(0, 63));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      if (m_axis_tready !== 1'b1 && budget > 100) m_axis_tready = ($urandom_range(0, 99) >= 30);
      n++;
    end
    m_axis_tready = 1'b1;
    chk(tag, busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_tdata"}, m_axis_tdata, '0);
    chk({tag, "_bram_en"}, bram_en, 1'b0);
    chk({tag, "_bram_addr"}, bram_addr, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_cfg_err"}, cfg_err, 1'b0);
  endtask

  task automatic start_and_check_latency(input string tag);
    dac_en = 1'b1;
    repeat (RD_LAT + 2) @(negedge aclk);
    chk({tag, "_no_early_beat"}, m_axis_tvalid, 1'b0);
    @(negedge aclk);
    chk({tag, "_first_beat"}, m_axis_tvalid, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  initial begin
    int b0, b1, n;
    n_cmp = 0; n_bad = 0; beats = 0; exp_idx = 0; reg_start = 0; reg_stop = 1;
    outstanding = 0; prev_stall = 1'b0; prev_data = '0;
    aresetn = 1'b0; dac_en = 1'b0; m_axis_tready = 1'b0; start_ptr = '0; stop_ptr = '0;
    for (int k = 0; k < MEM_WORDS; k++)
      for (int j = 0; j < DATA_W / 32; j++) mem[k][j*32 +: 32] = $urandom();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_all_zero("reset");
    tick();
    aresetn = 1'b1;
    tick();

    // Full 48-word loop, continuous tready: gapless and wrapping.
    set_region(0, 48);
    m_axis_tready = 1'b1;
    start_and_check_latency("s1");
    for (int i = 0; i < 120; i++) begin
      @(negedge aclk);
      chk("s1_no_gap", m_axis_tvalid, 1'b1);
    end
    chk("s1_cfg_err", cfg_err, 1'b0);
    tick();
    dac_en = 1'b0;
    wait_idle("s1_drain", 50);
    @(negedge aclk);
    chk("s1_idle_tvalid", m_axis_tvalid, 1'b0);

    // Random region, 30%-low tready, pointers scrambled mid-run.
    tick();
    n = $urandom_range(0, 40);
    set_region(n, n + $urandom_range(2, 20));
    b0 = beats;
    dac_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      m_axis_tready = ($urandom_range(0, 99) >= 30);
      if (i == 100) begin
        start_ptr = $urandom();
        stop_ptr  = $urandom();
      end
    end
    dac_en = 1'b0;
    wait_idle("s2_drain", 200);
    chk("s2_progress", (beats - b0) > 150, 1'b1);

    // Single-word region: word 1 on every beat.
    tick();
    set_region(1, 2);
    b0 = beats;
    dac_en = 1'b1;
    repeat (30) tick();
    dac_en = 1'b0;
    wait_idle("s3_drain", 50);
    chk("s3_progress", (beats - b0) >= 20, 1'b1);

    // Empty region: configuration error, nothing streamed.
    tick();
    set_region(48, 48);
    dac_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("s4_no_tvalid", m_axis_tvalid, 1'b0);
      chk("s4_no_busy", busy, 1'b0);
      chk("s4_no_read", bram_en, 1'b0);
    end
    chk("s4_cfg_err", cfg_err, 1'b1);
    tick();
    dac_en = 1'b0;
    tick();

    // Disable after 5 beats with the sink stalled: buffered words drain in order.
    set_region(0, 48);
    m_axis_tready = 1'b1;
    b0 = beats;
    dac_en = 1'b1;
    n = 0;
    while ((beats - b0) < 5 && n < 50) begin
      @(posedge aclk);
      n++;
    end
    chk("s5_five_beats", beats - b0, 5);
    #1;
    m_axis_tready = 1'b0;
    dac_en = 1'b0;
    b1 = beats;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("s5_stall_busy", busy, 1'b1);
    end
    tick();
    m_axis_tready = 1'b1;
    wait_idle("s5_drain", 50);
    chk("s5_drained_bounded", ((beats - b1) >= 1) && ((beats - b1) <= FIFO_DEPTH), 1'b1);
    @(negedge aclk);
    chk("s5_idle_tvalid", m_axis_tvalid, 1'b0);

    // Asynchronous reset mid-stream, then no restart until dac_en is re-raised.
    tick();
    set_region(3, 40);
    dac_en = 1'b1;
    repeat (20) tick();
    #2;
    aresetn = 1'b0;
    #1;
    chk_all_zero("s6_reset");
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("s6_no_restart_tvalid", m_axis_tvalid, 1'b0);
      chk("s6_no_restart_busy", busy, 1'b0);
    end
    tick();
    dac_en = 1'b0;
    tick();
    set_region(5, 9);
    start_and_check_latency("s6_restart");
    repeat (40) tick();
    dac_en = 1'b0;
    wait_idle("s6_drain", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_dac_streamer.md
Name: bram_dac_streamer

Overview:
- Playback engine between the AXI-loaded 512-bit sample BRAM (port B) and the 512-bit AXI-Stream DAC output.
- When the DAC-enable GPIO bit is set, it reads BRAM words from the start pointer up to the stop pointer, wrapping continuously.
- Each word is presented as one AXIS beat; tready backpressure is fully honoured.
- Start and stop pointers come from the start and stop GPIO registers.

Parameters:
- DATA_W, 512, BRAM word and tdata width in bits.
- ADDR_W, 32, BRAM byte-address width.
- RD_LAT, 2, BRAM read latency in cycles, from bram_en to valid bram_rddata (1..4).
- FIFO_DEPTH, 4, output buffer depth in words; must be >= RD_LAT+1.

Ports:
- aclk, in, 1, single clock for all logic.
- aresetn, in, 1, asynchronous active-low reset.
- dac_en, in, 1, GPIO DAC bit 0; level-sensitive run enable.
- start_ptr, in, 32, byte address of first word; bits [5:0] ignored.
- stop_ptr, in, 32, byte address one past last word (exclusive); bits [5:0] ignored.
- bram_addr, out, ADDR_W, BRAM byte address; always 64-byte aligned.
- bram_en, out, 1, BRAM read strobe.
- bram_rddata, in, DATA_W, BRAM read data, valid RD_LAT cycles after bram_en.
- m_axis_tdata, out, DATA_W, stream data.
- m_axis_tvalid, out, 1, stream valid.
- m_axis_tready, in, 1, stream ready.
- busy, out, 1, high in RUN or DRAIN.
- cfg_err, out, 1, sticky flag: enable was seen with stop word <= start word.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; in-flight count 0; cfg_err cleared.
- Word index: ptr[ADDR_W-1:6]. bram_addr = {word_idx, 6'b0}.
- States:
  - IDLE: on the dac_en rising edge, latch start_w/stop_w. If stop_w > start_w, go to RUN with cur_w = start_w. Otherwise set cfg_err and stay in IDLE.
  - RUN: issue a read (bram_en=1, addr=cur_w) in a cycle only when fifo_count + inflight < FIFO_DEPTH (credit rule; the FIFO never overflows). After each issue: cur_w = cur_w+1, or start_w when cur_w+1 == stop_w (wrap). dac_en low -> DRAIN, no further issues.
  - DRAIN: accept in-flight returns, keep streaming until the FIFO is empty and inflight is 0, then go to IDLE. A dac_en rise during DRAIN is ignored until IDLE is reached.
- Read return: a RD_LAT-deep valid shift register tags returns; a tagged return is pushed to the FIFO the same cycle.
- AXIS:
  - tvalid = FIFO not empty; tdata = FIFO head.
  - Pop on tvalid && tready.
  - Once asserted, tvalid/tdata stay stable until accepted, including through DRAIN.
- Throughput: 1 beat/cycle sustained under continuous tready. First beat appears RD_LAT+1 cycles after the dac_en rise is sampled.
- Pointer changes while in RUN/DRAIN are ignored; new values are used on the next enable.
- Single-word region (stop_w = start_w+1): that word repeats every beat.
- Push and pop in the same cycle: fifo_count is unchanged.
- Asynchronous reset mid-stream: immediate return to reset values; in-flight returns are discarded.
- cfg_err is cleared only by reset.

Optional Feature:
- BRAM_DAC_TLAST_EN.
  - Defined: adds output port m_axis_tlast (1 bit), FIFO width DATA_W+1. tlast=1 on the beat read from word stop_w-1, i.e. the end of each loop pass.
  - Undefined: no tlast port and no extra FIFO bit.

Decomposition:
- Package bram_dac_pkg holds:
  - BYTES_PER_WORD=64 and WORD_SHIFT=6.
  - State enum state_t {IDLE, RUN, DRAIN}.
  - A word-index typedef.
- One sub-module: stream_sync_fifo. Synchronous, parameterised width/depth, first-word-fall-through, count output. Instantiated once as the output buffer.

Test Plan:
- Preload word0=0x0001_0002..., word1=0x1111_2222...; start=0x0, stop=0xC00; dac_en=1 with tready=1. Expect beats word0, word1, ..., word47, then word0 again; no gaps after the first beat; first beat RD_LAT+1 cycles after enable.
- Same setup with tready toggled as a random 30%-low pattern. Expect no dropped or duplicated words; tdata stable while tvalid && !tready; at most FIFO_DEPTH words outstanding.
- start=0x40, stop=0x80. Expect word1 on every beat.
- start=0xC00, stop=0xC00, then dac_en=1. Expect cfg_err=1, tvalid never asserted, busy=0.
- Drop dac_en after 5 beats with tready=0 for 10 cycles, then release tready. Expect the buffered words to drain in order, then tvalid=0, busy=0, state IDLE.
- Assert aresetn=0 mid-stream for 3 cycles, then release. Expect all outputs 0 immediately; with dac_en still high, no restart until dac_en is lowered and raised again.
